// File: rtl/surf_merger_pkg.sv
// surf_merger_pkg: state encoding, header constants and default sizes for the SURF event merger
package surf_merger_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, STREAM, ADVANCE} state_t;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int HDR_BYTES = 4;
  localparam int DEF_NSURF = 7;
  localparam int DEF_EVENT_BYTES = 12292;
endpackage

// File: rtl/merger_skid.sv
// merger_skid: 2-entry AXI4-stream register slice (aclk, rst, s_valid/s_ready/s_data in, m_valid/m_ready/m_data out), s_ready registered as not-full
module merger_skid #(
  parameter int W = 9
) (
  input  logic         aclk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  logic         x_valid;
  logic [W-1:0] x_data;
  logic         pop;
  assign pop = m_ready | ~m_valid;
  assign s_ready = ~x_valid;
  always_ff @(posedge aclk)
    if (rst) begin
      m_valid <= 1'b0;
      x_valid <= 1'b0;
      m_data  <= '0;
      x_data  <= '0;
    end else if (pop) begin
      m_valid <= x_valid | s_valid;
      x_valid <= 1'b0;
      if (x_valid | s_valid) m_data <= x_valid ? x_data : s_data;
    end else if (s_valid & ~x_valid) begin
      x_valid <= 1'b1;
      x_data  <= s_data;
    end
endmodule

// File: rtl/surf_event_merger.sv
// surf_event_merger: merges one tlast-delimited event per SURF (s_dout_*) in order into one m_ev_* stream with event_count_o/event_done_o/len_err_o status; 4-byte header when SURF_MERGER_HEADER_EN is defined
module surf_event_merger
  import surf_merger_pkg::*;
#(
  parameter int    NSURF       = DEF_NSURF,
  parameter int    EVENT_BYTES = DEF_EVENT_BYTES,
  parameter string DEBUG       = "FALSE"
) (
  input  logic               aclk,
  input  logic               rst,
  input  logic [8*NSURF-1:0] s_dout_tdata,
  input  logic [NSURF-1:0]   s_dout_tvalid,
  input  logic [NSURF-1:0]   s_dout_tlast,
  output logic [NSURF-1:0]   s_dout_tready,
  output logic [7:0]         m_ev_tdata,
  output logic               m_ev_tvalid,
  output logic               m_ev_tlast,
  input  logic               m_ev_tready,
  output logic [15:0]        event_count_o,
  output logic               event_done_o,
  output logic [NSURF-1:0]   len_err_o
);
  localparam int SW = NSURF > 1 ? $clog2(NSURF) : 1;
  localparam int CW = $clog2(EVENT_BYTES + 1);
`ifdef SURF_MERGER_HEADER_EN
  localparam state_t FIRST = HEADER;
`else
  localparam state_t FIRST = STREAM;
`endif
  state_t        state, state_n;
  logic [SW-1:0] sel;
  logic [CW-1:0] byte_cnt;
  logic          sk_valid, sk_ready, in_hs, last_sel;
  logic [8:0]    sk_data, ev_data;
  assign last_sel = sel == SW'(NSURF - 1);
  assign in_hs = (state == STREAM) && s_dout_tvalid[sel] && sk_ready;
  assign {m_ev_tlast, m_ev_tdata} = ev_data;
`ifdef SURF_MERGER_HEADER_EN
  logic [1:0] hdr_idx;
  logic [7:0] hdr_byte;
  assign hdr_byte = hdr_idx == 2'd0 ? event_count_o[15:8] :
                    hdr_idx == 2'd1 ? event_count_o[7:0] :
                    hdr_idx == 2'd2 ? 8'(NSURF) : HDR_MAGIC;
  always_ff @(posedge aclk)
    if (rst) hdr_idx <= '0;
    else if (state == HEADER && sk_ready) hdr_idx <= hdr_idx + 2'd1;
`endif
  always_ff @(posedge aclk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s_dout_tvalid[0]) state_n = FIRST;
`ifdef SURF_MERGER_HEADER_EN
      HEADER:  if (sk_ready && hdr_idx == 2'(HDR_BYTES - 1)) state_n = STREAM;
`endif
      STREAM:  if (in_hs && s_dout_tlast[sel]) state_n = ADVANCE;
      ADVANCE: state_n = last_sel ? IDLE : STREAM;
      default: state_n = IDLE;
    endcase
  end
  // Only the last SURF's tlast survives into the merged stream.
  always_comb begin
    s_dout_tready = '0;
    sk_valid      = 1'b0;
    sk_data       = '0;
    if (state == STREAM) begin
      s_dout_tready[sel] = sk_ready;
      sk_valid           = s_dout_tvalid[sel];
      sk_data            = {s_dout_tlast[sel] & last_sel, s_dout_tdata[8*sel +: 8]};
    end
`ifdef SURF_MERGER_HEADER_EN
    if (state == HEADER) begin
      sk_valid = 1'b1;
      sk_data  = {1'b0, hdr_byte};
    end
`endif
  end
  // A saturated count can never be a legal length, so it always flags.
  always_ff @(posedge aclk)
    if (rst) begin
      sel           <= '0;
      byte_cnt      <= '0;
      event_count_o <= '0;
      event_done_o  <= 1'b0;
      len_err_o     <= '0;
    end else begin
      event_done_o <= m_ev_tvalid & m_ev_tready & m_ev_tlast;
      if (in_hs) begin
        byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 1'b1;
        if (s_dout_tlast[sel] && (&byte_cnt || byte_cnt != CW'(EVENT_BYTES - 1))) len_err_o[sel] <= 1'b1;
      end
      if (state == ADVANCE) begin
        byte_cnt <= '0;
        sel      <= last_sel ? '0 : sel + 1'b1;
        if (last_sel) event_count_o <= event_count_o + 16'd1;
      end
    end
  if (DEBUG == "TRUE") begin : g_dbg
    (* keep *) logic [2+SW+CW-1:0] probe;
    always_ff @(posedge aclk) probe <= {state, sel, byte_cnt};
  end
  merger_skid #(.W(9)) u_skid (
    .aclk    (aclk),
    .rst     (rst),
    .s_valid (sk_valid),
    .s_ready (sk_ready),
    .s_data  (sk_data),
    .m_valid (m_ev_tvalid),
    .m_ready (m_ev_tready),
    .m_data  (ev_data)
  );
endmodule

// File: tb/tb_surf_event_merger.sv
// tb_surf_event_merger: table-driven and scoreboarded check of surf_event_merger with short events
module tb_surf_event_merger;
  localparam int NS = 7;
  localparam int EB = 16;
`ifdef SURF_MERGER_HEADER_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif
  typedef struct {
    int vpct;
    int rpct;
    int bad_surf;
    int bad_len;
    int dly0;
    logic [NS-1:0] exp_err;
  } rec_t;
  logic aclk = 1'b0;
  logic rst = 1'b1;
  logic [8*NS-1:0] td = '0;
  logic [NS-1:0] tv = '0, tl = '0, tr;
  logic [7:0] m_data;
  logic m_valid, m_last;
  logic m_ready = 1'b0;
  logic [15:0] ev_cnt;
  logic ev_done;
  logic [NS-1:0] len_err;
  surf_event_merger #(.NSURF(NS), .EVENT_BYTES(EB)) dut (
    .aclk(aclk), .rst(rst),
    .s_dout_tdata(td), .s_dout_tvalid(tv), .s_dout_tlast(tl), .s_dout_tready(tr),
    .m_ev_tdata(m_data), .m_ev_tvalid(m_valid), .m_ev_tlast(m_last), .m_ev_tready(m_ready),
    .event_count_o(ev_cnt), .event_done_o(ev_done), .len_err_o(len_err)
  );
  always #5 aclk = ~aclk;
  int total = 0, bad = 0;
  logic [8:0] src_q[NS][$];
  logic [8:0] exp_q[$];
  int start_dly[NS];
  int surf_hs[NS];
  bit hs_pend[NS];
  int vpct = 100, rpct = 100, cur_surf = 0, out_bytes = 0, tlast_cnt = 0, done_cnt = 0, ev_idx = 0;
  bit drv_en = 1'b0, stalled = 1'b0;
  logic [8:0] held = '0;
  logic [15:0] model_count = '0;
  rec_t vec[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge aclk) begin
    if (!drv_en) begin
      tv = '0;
      tl = '0;
      m_ready = 1'b0;
      stalled = 1'b0;
      for (int i = 0; i < NS; i++) hs_pend[i] = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (hs_pend[i]) begin
          hs_pend[i] = 1'b0;
          tv[i] = 1'b0;
          void'(src_q[i].pop_front());
        end
        if (start_dly[i] > 0) start_dly[i]--;
        else if (!tv[i] && src_q[i].size() > 0 && $urandom_range(99) < vpct) begin
          tv[i] = 1'b1;
          {tl[i], td[8*i +: 8]} = src_q[i][0];
        end
      end
      if (stalled) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, held});
      m_ready = $urandom_range(99) < rpct;
      chk("ready_onehot0", 32'($onehot0(tr)), 1);
      for (int i = 0; i < NS; i++)
        if (tv[i] && tr[i]) begin
          hs_pend[i] = 1'b1;
          surf_hs[i]++;
          chk("surf_order", i, cur_surf);
          if (tl[i]) cur_surf = (cur_surf + 1) % NS;
        end
      if (m_valid && m_ready) begin
        out_bytes++;
        tlast_cnt += int'(m_last);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %0h want nothing", {m_last, m_data});
        end else chk("out_byte", {m_last, m_data}, exp_q.pop_front());
      end
      stalled = m_valid && !m_ready;
      held = {m_last, m_data};
      if (ev_done) done_cnt++;
    end
  end
  task automatic load_event(input rec_t r, output int exp_len);
    int len;
    logic [7:0] b;
    exp_len = HB;
`ifdef SURF_MERGER_HEADER_EN
    exp_q.push_back({1'b0, model_count[15:8]});
    exp_q.push_back({1'b0, model_count[7:0]});
    exp_q.push_back({1'b0, 8'(NS)});
    exp_q.push_back({1'b0, 8'hA5});
`endif
    for (int i = 0; i < NS; i++) begin
      len = (i == r.bad_surf) ? r.bad_len : EB;
      surf_hs[i] = 0;
      start_dly[i] = (i == 0) ? r.dly0 : 0;
      exp_len += len;
      for (int k = 0; k < len; k++) begin
        b = 8'(i * 37 + k + ev_idx * 11);
        src_q[i].push_back({k == len - 1, b});
        exp_q.push_back({i == NS - 1 && k == len - 1, b});
      end
    end
    ev_idx++;
    vpct = r.vpct;
    rpct = r.rpct;
    out_bytes = 0;
    tlast_cnt = 0;
    done_cnt = 0;
    drv_en = 1'b1;
  endtask
  task automatic finish_event(input rec_t r, input int exp_len, input string tag);
    int cyc = 0;
    while (!(exp_q.size() == 0 && done_cnt > 0) && cyc < 5000) begin
      @(posedge aclk);
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc < 5000), 1);
    repeat (3) @(posedge aclk);
    #1;
    model_count++;
    chk({tag, "_bytes"}, out_bytes, exp_len);
    chk({tag, "_tlast"}, tlast_cnt, 1);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_count"}, 32'(ev_cnt), 32'(model_count));
    chk({tag, "_len_err"}, 32'(len_err), 32'(r.exp_err));
  endtask
  initial begin
    int n, cyc;
    vec[0] = '{100, 100, -1, 0, 0, 7'b0000000};
    vec[1] = '{50, 50, -1, 0, 0, 7'b0000000};
    vec[2] = '{100, 100, -1, 0, 20, 7'b0000000};
    vec[3] = '{100, 100, 3, 10, 0, 7'b0001000};
    vec[4] = '{60, 40, 6, 40, 0, 7'b1001000};
    vec[5] = '{100, 100, 0, 15, 0, 7'b1001001};
    vec[6] = '{80, 70, 5, 17, 0, 7'b1101001};
    for (int i = 0; i < NS; i++) begin
      start_dly[i] = 0;
      surf_hs[i] = 0;
      hs_pend[i] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_valid), 0);
    chk("rst_tlast", 32'(m_last), 0);
    chk("rst_tready", 32'(tr), 0);
    chk("rst_count", 32'(ev_cnt), 0);
    chk("rst_done", 32'(ev_done), 0);
    chk("rst_len_err", 32'(len_err), 0);
    @(posedge aclk);
    #1 rst = 1'b0;
    for (int v = 0; v < 7; v++) begin
      load_event(vec[v], n);
      finish_event(vec[v], n, $sformatf("vec%0d", v));
    end
    load_event(vec[0], n);
    cyc = 0;
    while (surf_hs[1] < 5 && cyc < 2000) begin
      @(posedge aclk);
      cyc++;
    end
    chk("midrst_reach", 32'(cyc < 2000), 1);
    #1;
    rst = 1'b1;
    drv_en = 1'b0;
    @(posedge aclk);
    #1 rst = 1'b0;
    @(negedge aclk);
    #1;
    chk("midrst_tvalid", 32'(m_valid), 0);
    chk("midrst_tready", 32'(tr), 0);
    chk("midrst_count", 32'(ev_cnt), 0);
    chk("midrst_len_err", 32'(len_err), 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    cur_surf = 0;
    model_count = '0;
    load_event(vec[0], n);
    finish_event(vec[0], n, "post_rst");
    @(posedge aclk);
    #1 force dut.event_count_o = 16'hFFFF;
    @(posedge aclk);
    #1 release dut.event_count_o;
    model_count = 16'hFFFF;
    chk("preload_count", 32'(ev_cnt), 32'hFFFF);
    load_event(vec[0], n);
    finish_event(vec[0], n, "wrap");
    load_event(vec[1], n);
    finish_event(vec[1], n, "post_wrap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
